// File: rtl/button_conditioner_if.sv
// Purpose : bundles the pushbutton inputs and the conditioned outputs of button_conditioner.
// Latency : n/a (wires only).
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
//
// Signals: nBUT  raw active-low buttons (driven by the board side / master)
//          level debounced state, 1 = pressed
//          press one-cycle strobe on accepted press (and on each autorepeat)
//          rel   one-cycle strobe on accepted release ("release" is a reserved word)
interface button_conditioner_if #(
    parameter int NBUT = 2
);
    logic [NBUT-1:0] nBUT;
    logic [NBUT-1:0] level;
    logic [NBUT-1:0] press;
    logic [NBUT-1:0] rel;

    modport master (output nBUT, input level, input press, input rel);
    modport slave  (input nBUT, output level, output press, output rel);
endinterface

// File: rtl/button_conditioner.sv
// Purpose : per-button 2-FF sync, active-low inversion, counter debounce, press/release strobes.
// Latency : a clean nBUT edge is reflected on level/strobe at the (DEBOUNCE_CYCLES+2)th rising CLK edge.
// Backpressure: none; strobes are registered one-cycle pulses with no acknowledge.
//
// Ports: CLK (all flops on rising edge), RESET (synchronous, active-high, highest priority),
//        bus (button_conditioner_if.slave: nBUT in, level/press/rel out).
// Optional build macro BUTTON_AUTOREPEAT_EN adds per-button autorepeat: first repeat press
// REPEAT_DELAY cycles after the initial press strobe, then one every REPEAT_PERIOD cycles.
module button_conditioner #(
    parameter int NBUT            = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int REPEAT_DELAY    = 4096,
    parameter int REPEAT_PERIOD   = 512
) (
    input  logic                   CLK,
    input  logic                   RESET,
    button_conditioner_if.slave    bus
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NBUT-1:0] s1_q, s1_d;
    logic [NBUT-1:0] s2_q, s2_d;
    logic [NBUT-1:0] level_q, level_d;
    logic [NBUT-1:0] press_q, press_d;
    logic [NBUT-1:0] rel_q, rel_d;
    logic [NBUT-1:0] act;
    logic [NBUT-1:0] fire;
    logic [CW-1:0]   cnt_q [NBUT];
    logic [CW-1:0]   cnt_d [NBUT];

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int            RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW     = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]   rcnt_q [NBUT];
    logic [RW-1:0]   rcnt_d [NBUT];
    // rep_q marks that the first (long) repeat interval has elapsed
    logic [NBUT-1:0] rep_q, rep_d;
`endif

    always_comb begin
        s1_d = bus.nBUT;
        s2_d = s1_q;
        act  = ~s2_q;
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        fire    = '0;
        for (int i = 0; i < NBUT; i++) begin
            cnt_d[i] = '0;
            if (act[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                fire[i]    = 1'b1;
                level_d[i] = act[i];
                press_d[i] = act[i];
                rel_d[i]   = ~act[i];
            end
        end
`ifdef BUTTON_AUTOREPEAT_EN
        rep_d = rep_q;
        for (int i = 0; i < NBUT; i++) begin
            rcnt_d[i] = rcnt_q[i];
            // Clearing on !level covers the initial press edge; clearing on fire while
            // pressed is the release edge, which must never also emit a repeat.
            if (!level_q[i] || fire[i]) begin
                rcnt_d[i] = '0;
                rep_d[i]  = 1'b0;
            end else if (rcnt_q[i] == (rep_q[i] ? RP_MAX : RD_MAX)) begin
                rcnt_d[i]  = '0;
                rep_d[i]   = 1'b1;
                press_d[i] = 1'b1;
            end else begin
                rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q    <= '1;
            s2_q    <= '1;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < NBUT; i++) cnt_q[i] <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
            rep_q <= '0;
            for (int i = 0; i < NBUT; i++) rcnt_q[i] <= '0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            for (int i = 0; i < NBUT; i++) cnt_q[i] <= cnt_d[i];
`ifdef BUTTON_AUTOREPEAT_EN
            rep_q <= rep_d;
            for (int i = 0; i < NBUT; i++) rcnt_q[i] <= rcnt_d[i];
`endif
        end
    end

    assign bus.level = level_q;
    assign bus.press = press_q;
    assign bus.rel   = rel_q;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;

    button_conditioner_if #(.NBUT(2)) bif ();

    button_conditioner #(
        .NBUT(2),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(5)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bif)
    );

    always #5 CLK = ~CLK;

    // One segment: inputs held for len cycles; level goes pre->post and the strobes
    // fire at edge ev (1-based within the segment), ev=0 means no change.
    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] nbut;
        int         len;
        logic [1:0] lvl_pre;
        logic [1:0] lvl_post;
        int         ev;
        logic [1:0] ev_press;
        logic [1:0] ev_rel;
    } seg_t;

    seg_t segs [8];

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp_v);
        end
    endtask

    task automatic cyc(input string nm, input logic [1:0] lv, input logic [1:0] pr, input logic [1:0] rl);
        @(posedge CLK);
        #1;
        chk({nm, ".level"},   bif.level, lv);
        chk({nm, ".press"},   bif.press, pr);
        chk({nm, ".release"}, bif.rel,   rl);
        if ((bif.press & bif.rel) != 2'b00) begin
            errors++;
            $display("FAIL %s.exclusive at %0t: press %b release %b", nm, $time, bif.press, bif.rel);
        end
    endtask

    initial begin
        logic [1:0] lv, pr, rl;
        bif.nBUT = 2'b11;
        RESET    = 1'b1;

        segs[0] = '{"reset",        1'b1, 2'b11,  3, 2'b00, 2'b00,  0, 2'b00, 2'b00};
        segs[1] = '{"idle",         1'b0, 2'b11, 20, 2'b00, 2'b00,  0, 2'b00, 2'b00};
        segs[2] = '{"press0",       1'b0, 2'b10, 12, 2'b00, 2'b01, 10, 2'b01, 2'b00};
        segs[3] = '{"release0",     1'b0, 2'b11, 12, 2'b01, 2'b00, 10, 2'b00, 2'b01};
        segs[4] = '{"press1",       1'b0, 2'b01, 12, 2'b00, 2'b10, 10, 2'b10, 2'b00};
        segs[5] = '{"release1",     1'b0, 2'b11, 12, 2'b10, 2'b00, 10, 2'b00, 2'b10};
        segs[6] = '{"press_both",   1'b0, 2'b00, 12, 2'b00, 2'b11, 10, 2'b11, 2'b00};
        segs[7] = '{"release_both", 1'b0, 2'b11, 12, 2'b11, 2'b00, 10, 2'b00, 2'b11};

        for (int s = 0; s < 8; s++) begin
            RESET    = segs[s].rst;
            bif.nBUT = segs[s].nbut;
            for (int k = 1; k <= segs[s].len; k++) begin
                lv = (segs[s].ev != 0 && k >= segs[s].ev) ? segs[s].lvl_post : segs[s].lvl_pre;
                pr = (k == segs[s].ev) ? segs[s].ev_press : 2'b00;
                rl = (k == segs[s].ev) ? segs[s].ev_rel   : 2'b00;
                cyc(segs[s].name, lv, pr, rl);
            end
        end

        // Bounce: bit 0 toggles every 3 cycles for 30 cycles, then settles pressed.
        for (int t = 0; t < 30; t++) begin
            bif.nBUT = {1'b1, ((t / 3) % 2 == 1)};
            cyc("bounce", 2'b00, 2'b00, 2'b00);
        end
        bif.nBUT = 2'b10;
        for (int k = 1; k <= 11; k++) begin
            cyc("bounce_settle", (k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00, 2'b00);
        end
        bif.nBUT = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            cyc("bounce_release", (k >= 10) ? 2'b00 : 2'b01, 2'b00, (k == 10) ? 2'b01 : 2'b00);
        end

        // Reset mid-debounce: count reaches 5 after 7 edges, then RESET for 2 cycles.
        bif.nBUT = 2'b10;
        for (int k = 1; k <= 7; k++) cyc("pre_reset", 2'b00, 2'b00, 2'b00);
        RESET = 1'b1;
        for (int k = 1; k <= 2; k++) cyc("mid_reset", 2'b00, 2'b00, 2'b00);
        RESET = 1'b0;

        // Re-detect at edge 10 after reset, then hold; release lands at edge 55,
        // exactly where a repeat would otherwise fall.
        for (int k = 1; k <= 55; k++) begin
            logic rep;
            rep = AR && (k >= 30) && ((k - 30) % 5 == 0) && (k < 55);
            lv = (k >= 10 && k < 55) ? 2'b01 : 2'b00;
            pr = (k == 10 || rep) ? 2'b01 : 2'b00;
            rl = (k == 55) ? 2'b01 : 2'b00;
            cyc("hold_repeat", lv, pr, rl);
            if (k == 45) bif.nBUT = 2'b11;
        end

        for (int k = 1; k <= 5; k++) cyc("final_idle", 2'b00, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
